syn_fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the synchronous FIFO between NUM_REQ independent producers in the clk_wr_i domain.
- Grants are round-robin and burst-based: one producer at a time, for up to MAX_BURST words.
- Drives the FIFO wr_i/data_in_i pair and honours the FIFO's synchronised full flag.
- Sits directly in front of the FIFO write side and is the only agent allowed to write it.

---
 rtl/syn_fifo_arb_pkg.sv | 17 +
 rtl/syn_fifo_wr_arbiter_rr_picker.sv | 32 +++
 rtl/syn_fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_syn_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_arb_pkg.sv
// syn_fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter
package syn_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FULL_STALL_LIMIT = 4;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/syn_fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or above start
module rr_picker
    import syn_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] start,
    output logic [NUM_REQ-1:0]        pick,
    output logic                      valid
);

    localparam int IW = clog2(NUM_REQ);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // walk from start upward, wrapping at NUM_REQ, and keep the first hit
    always_comb begin
        pick = '0;
        sum  = '0;
        idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, start} + (IW+1)'(i);
            idx = IW'((sum >= (IW+1)'(NUM_REQ)) ? sum - (IW+1)'(NUM_REQ) : sum);
            if (pick == '0 && req[idx]) pick[idx] = 1'b1;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/syn_fifo_wr_arbiter.sv
// syn_fifo_wr_arbiter: burst-based round-robin sharing of the FIFO write port
module syn_fifo_wr_arbiter
    import syn_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int MAX_BURST  = 8
) (
    input  logic                          rst_n_i,
    input  logic                          clk_wr_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic [15:0]                   word_cnt_o
);

    localparam int IW = clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = clog2(FULL_STALL_LIMIT);

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      next_ptr;
    logic [BW-1:0]      burst_cnt;
    logic [SW-1:0]      stall_cnt;
    logic [15:0]        word_cnt;
    logic               accept;
    logic               owner_valid;
    logic               last_word;
    logic               stall_out;
    logic               leave;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_valid_i),
        .start (rr_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    // owner index and data mux; grant is zero outside BURST so data is zero there
    always_comb begin
        owner       = '0;
        fifo_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                owner       = IW'(k);
                fifo_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready_o = grant & {NUM_REQ{~fifo_full_i}};
    assign accept      = |(req_valid_i & req_ready_o);
    assign fifo_wr_o   = accept;
    assign owner_valid = |(req_valid_i & grant);
    assign last_word   = accept && (burst_cnt == BW'(MAX_BURST - 1));
    assign stall_out   = fifo_full_i && (stall_cnt == SW'(FULL_STALL_LIMIT - 1));
    assign leave       = last_word || !owner_valid || stall_out;
    assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign grant_o     = grant;
    assign busy_o      = (state == BURST);
    assign word_cnt_o  = word_cnt;

    // arbitration FSM: grant from IDLE, release on burst end, owner drop or blocked FIFO
    always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_valid && !fifo_full_i) begin
                state     <= BURST;
                grant     <= pick;
                burst_cnt <= '0;
                stall_cnt <= '0;
            end
        end else if (leave) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
        end else begin
            burst_cnt <= burst_cnt + BW'(accept);
            stall_cnt <= fifo_full_i ? stall_cnt + 1'b1 : '0;
        end
    end

    // running count of words written into the FIFO
    always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
        if (!rst_n_i) word_cnt <= '0;
        else if (fifo_wr_o) word_cnt <= word_cnt + 1'b1;
    end

endmodule

// File: tb/tb_syn_fifo_wr_arbiter.sv
// tb_syn_fifo_wr_arbiter: cycle table plus scoreboarded streaming checks for the write arbiter
module tb_syn_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  vld;
    logic [N*DW-1:0] dat;
    logic          full;
    logic [N-1:0]  rdy;
    logic          wr;
    logic [DW-1:0] fd;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [15:0]   wcnt;

    always #5 clk = ~clk;

    syn_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .rst_n_i     (rst_n),
        .clk_wr_i    (clk),
        .req_valid_i (vld),
        .req_data_i  (dat),
        .req_ready_o (rdy),
        .fifo_full_i (full),
        .fifo_wr_o   (wr),
        .fifo_data_o (fd),
        .grant_o     (gnt),
        .busy_o      (busy),
        .word_cnt_o  (wcnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    typedef struct packed {
        logic [3:0]  v;
        logic        f;
        logic [3:0]  g;
        logic [3:0]  r;
        logic        w;
        logic        b;
        logic [15:0] c;
    } row_t;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc_n = 0;
    int         seq[N];
    int         lim[N];
    logic [N-1:0] en;
    logic       sb_on;
    exp_t       q[$];
    row_t       rows[$];

    function automatic logic [DW-1:0] word(input int k, input int s);
        return DW'((k << 12) | s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            vld[k] = en[k] && (seq[k] < lim[k]);
            dat[k*DW +: DW] = word(k, seq[k]);
        end
    endtask

    task automatic finish_cycle();
        logic [N-1:0] sv;
        logic [N-1:0] sr;
        exp_t e;
        if (sb_on && wr) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra_write: got data 0x%0h expected no write (cycle %0d)", fd, cyc_n);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(fd), 32'(e.d));
                chk("sb_cycle", cyc_n, e.c);
            end
        end
        sv = vld;
        sr = rdy;
        @(posedge clk);
        for (int k = 0; k < N; k++) if (sv[k] && sr[k]) seq[k]++;
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic tick();
        drive();
        #2;
        finish_cycle();
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, 32'(rdy), 0);
        chk({p, "_wr"}, 32'(wr), 0);
        chk({p, "_data"}, 32'(fd), 0);
        chk({p, "_grant"}, 32'(gnt), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_wcnt"}, 32'(wcnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = '0;
        full  = 1'b0;
        for (int k = 0; k < N; k++) begin
            seq[k] = 0;
            lim[k] = 1000;
        end
        q.delete();
        drive();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_n = 0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() > 0; i++) tick();
        chk("sb_drain_left", q.size(), 0);
    endtask

    task automatic add_row(input logic [3:0] v, input logic f, input logic [3:0] g, input logic [3:0] r,
                           input logic w, input logic b, input logic [15:0] c);
        rows.push_back({v, f, g, r, w, b, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        full  = 1'b0;
        en    = '0;
        sb_on = 1'b0;
        vld   = '0;
        dat   = '0;
        @(negedge clk);

        // early release, full stall, full timeout, cycle by cycle
        add_row(4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add_row(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 0);
        add_row(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 1);
        add_row(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 2);
        add_row(4'b0101, 0, 4'b0010, 4'b0010, 0, 1, 3);
        add_row(4'b0101, 0, 4'b0000, 4'b0000, 0, 0, 3);
        add_row(4'b0101, 0, 4'b0100, 4'b0100, 1, 1, 3);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 4);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 4);
        add_row(4'b0101, 0, 4'b0100, 4'b0100, 1, 1, 4);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 5);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 5);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 5);
        add_row(4'b0101, 1, 4'b0100, 4'b0000, 0, 1, 5);
        add_row(4'b1101, 1, 4'b0000, 4'b0000, 0, 0, 5);
        add_row(4'b1101, 1, 4'b0000, 4'b0000, 0, 0, 5);
        add_row(4'b1101, 0, 4'b0000, 4'b0000, 0, 0, 5);
        add_row(4'b1101, 0, 4'b1000, 4'b1000, 1, 1, 5);
        do_reset();
        sb_on = 1'b0;
        foreach (rows[i]) begin
            en   = rows[i].v;
            full = rows[i].f;
            drive();
            #2;
            chk($sformatf("tbl%0d_grant", i), 32'(gnt), 32'(rows[i].g));
            chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(rows[i].r));
            chk($sformatf("tbl%0d_wr", i), 32'(wr), 32'(rows[i].w));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(rows[i].b));
            chk($sformatf("tbl%0d_wcnt", i), 32'(wcnt), 32'(rows[i].c));
            if (!rows[i].b) chk($sformatf("tbl%0d_data_idle", i), 32'(fd), 0);
            finish_cycle();
        end

        // single requester: bursts 8, 8, 4 with one bubble each
        do_reset();
        sb_on  = 1'b1;
        lim[2] = 20;
        en     = 4'b0100;
        for (int i = 0; i < 20; i++) q.push_back('{word(2, i), i + 1 + i / 8});
        drain(60);
        tick();
        tick();
        chk("single_wcnt", 32'(wcnt), 20);
        chk("single_idle", 32'(busy), 0);

        // all requesters valid: grant order 0,1,2,3,0 in bursts of 8
        do_reset();
        sb_on = 1'b1;
        en    = 4'b1111;
        for (int i = 0; i < 40; i++) q.push_back('{word((i / 8) % 4, (i / 32) * 8 + i % 8), i + 1 + i / 8});
        drain(100);
        chk("rr_wcnt", 32'(wcnt), 40);

        // reset asserted while the fifth word is on the write port
        do_reset();
        sb_on = 1'b1;
        en    = 4'b1110;
        for (int i = 0; i < 4; i++) q.push_back('{word(1, i), i + 1});
        repeat (5) tick();
        drive();
        #2;
        chk("mrst_wr_before", 32'(wr), 1);
        chk("mrst_grant_before", 32'(gnt), 32'(4'b0010));
        rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) seq[k] = 0;
        en    = 4'b1111;
        sb_on = 1'b0;
        rst_n = 1'b1;
        cyc_n = 0;
        tick();
        drive();
        #2;
        chk("mrst_first_grant", 32'(gnt), 32'(4'b0001));
        chk("mrst_first_wr", 32'(wr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
